mem_arbiter: RTL and testbench

//  Shares one mem_system_hier instance between the fetch requester (port 0) and the data requester (port 1).

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_pick.sv | 25 ++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and
// requester port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } arb_state_t;

  localparam logic P_FETCH = 1'b0;
  localparam logic P_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational grant selection between the fetch port (0) and data port (1).
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic any_req,
  output logic gnt
);

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      gnt = (FAIR != 0) ? ~last_gnt : P_DATA;
    end else if (req1) begin
      gnt = P_DATA;
    end else begin
      gnt = P_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto a single memory system, one
// transaction at a time, returning registered read data and a done pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int FAIR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_rd,
  input  logic [AW-1:0] p0_addr,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_done,
  output logic          p0_stall,
  input  logic          p1_rd,
  input  logic          p1_wr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_done,
  output logic          p1_stall,
  input  logic          halt,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_rd,
  output logic          m_wr,
  output logic          m_dump,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_done,
  input  logic          m_err,
  output logic          err
);

  arb_state_t    state, state_nxt;
  logic          gnt, last_gnt, pick_gnt, any_req;
  logic          dumped, issue;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          lat_rd, lat_wr;

  mem_arb_pick #(.FAIR(FAIR)) u_pick (
    .req0     (p0_rd),
    .req1     (p1_rd | p1_wr),
    .last_gnt (last_gnt),
    .any_req  (any_req),
    .gnt      (pick_gnt)
  );

  // Once a dump has been requested, grants stay blocked until halt drops.
  always_comb begin
    m_dump    = halt && (state == IDLE) && !p0_rd && !p1_rd && !p1_wr;
    issue     = (state == IDLE) && any_req && !(halt && dumped);
    state_nxt = state;
    case (state)
      IDLE:    if (issue)  state_nxt = BUSY;
      BUSY:    if (m_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_addr   = lat_addr;
    m_wdata  = lat_wdata;
    m_rd     = (state == BUSY) && lat_rd;
    m_wr     = (state == BUSY) && lat_wr;
    p0_done  = (state == RESP) && (gnt == P_FETCH);
    p1_done  = (state == RESP) && (gnt == P_DATA);
    p0_stall = p0_rd && !p0_done;
    p1_stall = (p1_rd || p1_wr) && !p1_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= P_FETCH;
      last_gnt  <= P_DATA;
      dumped    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      state  <= state_nxt;
      dumped <= halt && (dumped || m_dump);
      if ((state == IDLE) && p1_rd && p1_wr) err <= 1'b1;
      if (issue) begin
        gnt <= pick_gnt;
        if (pick_gnt == P_DATA) begin
          lat_addr  <= p1_addr;
          lat_wdata <= p1_wdata;
          lat_rd    <= p1_rd && !p1_wr;  // rd+wr together resolves to a store
          lat_wr    <= p1_wr;
        end else begin
          lat_addr  <= p0_addr;
          lat_wdata <= '0;
          lat_rd    <= 1'b1;
          lat_wr    <= 1'b0;
        end
      end
      if (state == BUSY) begin
        if (m_err) err <= 1'b1;
        if (m_done) begin
          if (gnt == P_DATA) p1_rdata <= m_rdata;
          else               p0_rdata <= m_rdata;
          last_gnt <= gnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 is built with FAIR=1, instance 1
// with FAIR=0; the bench plays the memory side by hand.
module tb_mem_arbiter;

  logic        clk;
  logic        rst[2], p0_rd[2], p1_rd[2], p1_wr[2], halt[2], m_done[2], m_err[2];
  logic [15:0] p0_addr[2], p1_addr[2], p1_wdata[2], m_rdata[2];
  logic [15:0] p0_rdata[2], p1_rdata[2], m_addr[2], m_wdata[2];
  logic        p0_done[2], p0_stall[2], p1_done[2], p1_stall[2];
  logic        m_rd[2], m_wr[2], m_dump[2], err[2];

  int tests = 0;
  int failed = 0;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    mem_arbiter #(.AW(16), .DW(16), .FAIR((i == 0) ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst[i]),
      .p0_rd(p0_rd[i]), .p0_addr(p0_addr[i]), .p0_rdata(p0_rdata[i]),
      .p0_done(p0_done[i]), .p0_stall(p0_stall[i]),
      .p1_rd(p1_rd[i]), .p1_wr(p1_wr[i]), .p1_addr(p1_addr[i]), .p1_wdata(p1_wdata[i]),
      .p1_rdata(p1_rdata[i]), .p1_done(p1_done[i]), .p1_stall(p1_stall[i]),
      .halt(halt[i]), .m_addr(m_addr[i]), .m_wdata(m_wdata[i]),
      .m_rd(m_rd[i]), .m_wr(m_wr[i]), .m_dump(m_dump[i]),
      .m_rdata(m_rdata[i]), .m_done(m_done[i]), .m_err(m_err[i]), .err(err[i])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failed=%0d", failed);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        p0_rd;
    logic [15:0] p0_addr;
    logic        p1_rd, p1_wr;
    logic [15:0] p1_addr, p1_wdata, mdata;
    int          lat;
    logic        exp_gnt, exp_rd, exp_wr;
    logic [15:0] exp_addr, exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs(input int d);
    p0_rd[d] = 1'b0; p1_rd[d] = 1'b0; p1_wr[d] = 1'b0; halt[d] = 1'b0;
    m_done[d] = 1'b0; m_err[d] = 1'b0; m_rdata[d] = 16'hDEAD;
    p0_addr[d] = '0; p1_addr[d] = '0; p1_wdata[d] = '0;
  endtask

  task automatic do_reset(input int d);
    @(posedge clk); #1;
    rst[d] = 1'b1;
    clear_inputs(d);
    @(posedge clk);
    @(posedge clk); #1;
    rst[d] = 1'b0;
  endtask

  // Called at posedge+1 of the cycle the request is presented; returns at the
  // negedge of the cycle that follows m_done.
  task automatic serve(input int d, input int lat, input logic [15:0] mdata, input logic merr,
                       input int mode, output logic ok, output int wt,
                       output logic srd, output logic swr, output logic [15:0] saddr,
                       output logic [15:0] swdata, output logic stable,
                       output logic d0, output logic d1, output logic [15:0] r0,
                       output logic [15:0] r1);
    ok = 1'b0; wt = 0; srd = 1'b0; swr = 1'b0; saddr = '0; swdata = '0;
    stable = 1'b1; d0 = 1'b0; d1 = 1'b0; r0 = '0; r1 = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_rd[d] || m_wr[d]) begin
        ok = 1'b1;
        wt = n;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) return;
    srd = m_rd[d]; swr = m_wr[d]; saddr = m_addr[d]; swdata = m_wdata[d];
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (mode == 1 && k == 1) begin
        p1_addr[d]  = ~p1_addr[d];
        p1_wdata[d] = ~p1_wdata[d];
      end
      if (mode == 2 && k == 1) begin
        p0_rd[d] = 1'b0; p1_rd[d] = 1'b0; p1_wr[d] = 1'b0;
      end
      if (k == lat) begin
        m_done[d] = 1'b1; m_rdata[d] = mdata; m_err[d] = merr;
      end
      @(negedge clk);
      if (m_addr[d] !== saddr || m_rd[d] !== srd || m_wr[d] !== swr || m_wdata[d] !== swdata)
        stable = 1'b0;
    end
    @(posedge clk); #1;
    m_done[d] = 1'b0; m_err[d] = 1'b0; m_rdata[d] = 16'hDEAD;
    @(negedge clk);
    d0 = p0_done[d]; d1 = p1_done[d]; r0 = p0_rdata[d]; r1 = p1_rdata[d];
  endtask

  vec_t        vt[6];
  logic        ok, srd, swr, stable, d0, d1;
  logic [15:0] saddr, swdata, r0, r1;
  int          wt, cnt;
  logic        gexp;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      clear_inputs(d);
    end

    vt[0] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000};
    vt[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h7777, 16'hA5A5, 2, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000};
    vt[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'hBEEF};
    vt[3] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h3C3C, 1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000};
    vt[4] = '{1'b1, 16'h0030, 1'b0, 1'b1, 16'h0034, 16'h5555, 16'h0000, 3, 1'b1, 1'b0, 1'b1, 16'h0034, 16'h5555};
    vt[5] = '{1'b1, 16'h0FFE, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 4, 1'b0, 1'b1, 1'b0, 16'h0FFE, 16'h0000};

    do_reset(1);
    do_reset(0);

    // Reset state
    @(negedge clk);
    chk("rst_m_rd", m_rd[0], 1'b0);
    chk("rst_m_wr", m_wr[0], 1'b0);
    chk("rst_m_dump", m_dump[0], 1'b0);
    chk("rst_dones", {p0_done[0], p1_done[0]}, 2'b00);
    chk("rst_err", err[0], 1'b0);
    chk("rst_m_addr", m_addr[0], 16'h0000);
    chk("rst_rdata", {p0_rdata[0], p1_rdata[0]}, 32'h0);

    // Single fetch, m_done one cycle after m_rd
    @(posedge clk); #1;
    p0_rd[0] = 1'b1; p0_addr[0] = 16'h0040;
    @(negedge clk);
    chk("sf_c0_stall", p0_stall[0], 1'b1);
    chk("sf_c0_m_rd", m_rd[0], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sf_c1_m_rd", m_rd[0], 1'b1);
    chk("sf_c1_m_addr", m_addr[0], 16'h0040);
    chk("sf_c1_stall", p0_stall[0], 1'b1);
    @(posedge clk); #1;
    m_done[0] = 1'b1; m_rdata[0] = 16'hC0DE;
    @(negedge clk);
    chk("sf_c2_stall", p0_stall[0], 1'b1);
    chk("sf_c2_done", p0_done[0], 1'b0);
    @(posedge clk); #1;
    m_done[0] = 1'b0; m_rdata[0] = 16'hDEAD;
    @(negedge clk);
    chk("sf_c3_done", {p0_done[0], p1_done[0]}, 2'b10);
    chk("sf_c3_rdata", p0_rdata[0], 16'hC0DE);
    chk("sf_c3_stall", p0_stall[0], 1'b0);
    @(posedge clk); #1;
    p0_rd[0] = 1'b0;
    @(negedge clk);
    chk("sf_c4_done", p0_done[0], 1'b0);
    chk("sf_c4_rdata_hold", p0_rdata[0], 16'hC0DE);

    // Table-driven single transactions (FAIR=1)
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      p0_rd[0] = vt[v].p0_rd; p0_addr[0] = vt[v].p0_addr;
      p1_rd[0] = vt[v].p1_rd; p1_wr[0] = vt[v].p1_wr;
      p1_addr[0] = vt[v].p1_addr; p1_wdata[0] = vt[v].p1_wdata;
      serve(0, vt[v].lat, vt[v].mdata, 1'b0, 0, ok, wt, srd, swr, saddr, swdata, stable, d0, d1, r0, r1);
      chk($sformatf("v%0d_issued", v), ok, 1'b1);
      chk($sformatf("v%0d_latency", v), wt, 1);
      chk($sformatf("v%0d_rd_wr", v), {srd, swr}, {vt[v].exp_rd, vt[v].exp_wr});
      chk($sformatf("v%0d_addr", v), saddr, vt[v].exp_addr);
      if (vt[v].exp_wr) chk($sformatf("v%0d_wdata", v), swdata, vt[v].exp_wdata);
      chk($sformatf("v%0d_stable", v), stable, 1'b1);
      chk($sformatf("v%0d_done", v), {d0, d1}, {~vt[v].exp_gnt, vt[v].exp_gnt});
      chk($sformatf("v%0d_rdata", v), vt[v].exp_gnt ? r1 : r0, vt[v].mdata);
      @(posedge clk); #1;
      clear_inputs(0);
      @(negedge clk);
      chk($sformatf("v%0d_after", v), {p0_done[0], p1_done[0], m_rd[0], m_wr[0]}, 4'b0);
    end

    // FAIR=1 contention, both held, from reset (last_gnt=1): 0,1,0,1
    do_reset(0);
    p0_rd[0] = 1'b1; p0_addr[0] = 16'h0040;
    p1_wr[0] = 1'b1; p1_addr[0] = 16'h0100; p1_wdata[0] = 16'hBEEF;
    for (int t = 0; t < 4; t++) begin
      gexp = (t % 2 == 1);
      serve(0, 1, 16'h4444, 1'b0, 0, ok, wt, srd, swr, saddr, swdata, stable, d0, d1, r0, r1);
      chk($sformatf("fair_t%0d_issue_gap", t), wt, 1);
      chk($sformatf("fair_t%0d_done", t), {d0, d1}, {~gexp, gexp});
      chk($sformatf("fair_t%0d_addr", t), saddr, gexp ? 16'h0100 : 16'h0040);
      chk($sformatf("fair_t%0d_op", t), {srd, swr}, gexp ? 2'b01 : 2'b10);
      if (gexp) chk($sformatf("fair_t%0d_wdata", t), swdata, 16'hBEEF);
      @(posedge clk); #1;
    end
    clear_inputs(0);

    // FAIR=0 contention on instance 1: port 1 wins until it deasserts
    p0_rd[1] = 1'b1; p0_addr[1] = 16'h0A00;
    p1_rd[1] = 1'b1; p1_addr[1] = 16'h0B00;
    @(posedge clk); #1;
    for (int t = 0; t < 3; t++) begin
      serve(1, 1, 16'h6000 + 16'(t), 1'b0, 0, ok, wt, srd, swr, saddr, swdata, stable, d0, d1, r0, r1);
      chk($sformatf("pri_t%0d_done", t), {d0, d1}, 2'b01);
      chk($sformatf("pri_t%0d_addr", t), saddr, 16'h0B00);
      chk($sformatf("pri_t%0d_rdata", t), r1, 16'h6000 + 16'(t));
      @(posedge clk); #1;
    end
    p1_rd[1] = 1'b0;
    serve(1, 1, 16'h7001, 1'b0, 0, ok, wt, srd, swr, saddr, swdata, stable, d0, d1, r0, r1);
    chk("pri_p0_done", {d0, d1}, 2'b10);
    chk("pri_p0_addr", saddr, 16'h0A00);
    @(posedge clk); #1;
    clear_inputs(1);

    // Slow memory with mid-flight address change
    p1_rd[0] = 1'b1; p1_addr[0] = 16'h0300;
    serve(0, 20, 16'h9999, 1'b0, 1, ok, wt, srd, swr, saddr, swdata, stable, d0, d1, r0, r1);
    chk("slow_addr", saddr, 16'h0300);
    chk("slow_stable", stable, 1'b1);
    chk("slow_done", {d0, d1}, 2'b01);
    chk("slow_rdata", r1, 16'h9999);
    @(posedge clk); #1;
    clear_inputs(0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt += int'(p1_done[0]);
      @(posedge clk); #1;
    end
    chk("slow_single_pulse", cnt, 0);

    // Request dropped before done is still completed
    p0_rd[0] = 1'b1; p0_addr[0] = 16'h0050;
    serve(0, 3, 16'h0055, 1'b0, 2, ok, wt, srd, swr, saddr, swdata, stable, d0, d1, r0, r1);
    chk("drop_done", {d0, d1}, 2'b10);
    chk("drop_rdata", r0, 16'h0055);
    @(posedge clk); #1;

    // m_err in BUSY
    do_reset(0);
    p0_rd[0] = 1'b1; p0_addr[0] = 16'h0060;
    serve(0, 1, 16'h0066, 1'b1, 0, ok, wt, srd, swr, saddr, swdata, stable, d0, d1, r0, r1);
    chk("merr_done", {d0, d1}, 2'b10);
    chk("merr_err", err[0], 1'b1);
    @(posedge clk); #1;
    clear_inputs(0);
    @(negedge clk);
    chk("merr_sticky", err[0], 1'b1);

    // p1_rd and p1_wr together
    do_reset(0);
    @(negedge clk);
    chk("rdwr_err_clear", err[0], 1'b0);
    @(posedge clk); #1;
    p1_rd[0] = 1'b1; p1_wr[0] = 1'b1; p1_addr[0] = 16'h0400; p1_wdata[0] = 16'h1111;
    serve(0, 1, 16'h0000, 1'b0, 0, ok, wt, srd, swr, saddr, swdata, stable, d0, d1, r0, r1);
    chk("rdwr_op", {srd, swr}, 2'b01);
    chk("rdwr_wdata", swdata, 16'h1111);
    chk("rdwr_done", {d0, d1}, 2'b01);
    chk("rdwr_err", err[0], 1'b1);
    @(posedge clk); #1;
    clear_inputs(0);

    // Halt: dump, then no grants while halt stays high
    do_reset(0);
    halt[0] = 1'b1;
    @(negedge clk);
    chk("halt_dump", m_dump[0], 1'b1);
    @(posedge clk); #1;
    p0_rd[0] = 1'b1; p0_addr[0] = 16'h0090;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt += int'(m_rd[0] | m_wr[0] | m_dump[0]);
      @(posedge clk); #1;
    end
    chk("halt_no_grant", cnt, 0);
    halt[0] = 1'b0;
    serve(0, 1, 16'h0099, 1'b0, 0, ok, wt, srd, swr, saddr, swdata, stable, d0, d1, r0, r1);
    chk("unhalt_grant", ok, 1'b1);
    chk("unhalt_done", {d0, d1}, 2'b10);
    @(posedge clk); #1;
    clear_inputs(0);

    // Reset in the middle of BUSY
    @(posedge clk); #1;
    p0_rd[0] = 1'b1; p0_addr[0] = 16'h0070;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_busy", m_rd[0], 1'b1);
    @(posedge clk); #1;
    rst[0] = 1'b1; p0_rd[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0; m_done[0] = 1'b1; m_rdata[0] = 16'h7777;
    @(negedge clk);
    chk("rb_idle", {m_rd[0], m_wr[0], p0_done[0]}, 3'b000);
    @(posedge clk); #1;
    m_done[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt += int'(p0_done[0] | p1_done[0] | m_rd[0]);
      @(posedge clk); #1;
    end
    chk("rb_no_done", cnt, 0);
    chk("rb_rdata", p0_rdata[0], 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
